// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter and its round-robin picker.
package mem_arbiter_pkg;

    // Byte-enable mask of a 16-bit LC-3b memory word (MASK_WIDTH = 2).
    typedef logic [1:0] lc3b_mem_wmask;

    // Arbiter control states: IDLE looks for a requester, BUSY waits for mem_resp.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Width of a channel index; never zero so a 1-channel build still elaborates.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester after last_grant, wrapping mod NUM_PORTS.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     grant,
    output logic                 any_req
);

    int unsigned cand;

    // Scan last_grant+1 .. last_grant+NUM_PORTS; explicit wrap keeps non-power-of-two counts correct.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = 32'(last_grant) + k;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                grant   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter sharing one registered memory port; one transaction in flight.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             port_read,
    input  logic [NUM_PORTS-1:0]             port_write,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  port_byte_enable,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
    output logic [NUM_PORTS-1:0]             port_resp,
    output logic [DATA_WIDTH-1:0]            port_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [MASK_WIDTH-1:0]            mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_resp,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int unsigned        IdxW    = idx_width(NUM_PORTS);
    localparam logic [IdxW-1:0]    LastIdx = IdxW'(NUM_PORTS - 1);

    arb_state_t             state_q, state_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [IdxW-1:0]        last_grant_q, last_grant_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [MASK_WIDTH-1:0]  mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

    logic [NUM_PORTS-1:0]   req;
    logic [IdxW-1:0]        pick_idx;
    logic                   any_req;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_PORTS];
    logic [MASK_WIDTH-1:0]  be_arr    [NUM_PORTS];

    assign req = port_read | port_write;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IdxW)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_idx),
        .any_req    (any_req)
    );

    // Unpack the per-channel command buses into arrays indexed by channel.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            addr_arr[i]  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            be_arr[i]    = port_byte_enable[i*MASK_WIDTH +: MASK_WIDTH];
        end
    end

    // Next-state: latch the picked command in IDLE, hold it in BUSY until mem_resp.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d     = pick_idx;
                    mem_addr_d  = addr_arr[pick_idx];
                    mem_wdata_d = wdata_arr[pick_idx];
                    mem_be_d    = be_arr[pick_idx];
                    // Write wins when a channel raises both strobes.
                    mem_write_d = port_write[pick_idx];
                    mem_read_d  = port_read[pick_idx] & ~port_write[pick_idx];
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    last_grant_d = grant_q;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and registered downstream command; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= LastIdx;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Completion pulse goes only to the granted channel, only while BUSY.
    always_comb begin
        port_resp = '0;
        if (state_q == ARB_BUSY && mem_resp) begin
            port_resp[grant_q] = 1'b1;
        end
    end

    assign port_rdata      = mem_rdata;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_address     = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for a 3-channel mem_arbiter against a round-robin reference model.
module tb_mem_arbiter;

    localparam int NP = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 2;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     port_read;
    logic [NP-1:0]     port_write;
    logic [NP*MW-1:0]  port_byte_enable;
    logic [NP*AW-1:0]  port_address;
    logic [NP*DW-1:0]  port_wdata;
    logic [NP-1:0]     port_resp;
    logic [DW-1:0]     port_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [MW-1:0]     mem_byte_enable;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_wdata;
    logic              mem_resp;
    logic [DW-1:0]     mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MASK_WIDTH (MW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .port_read        (port_read),
        .port_write       (port_write),
        .port_byte_enable (port_byte_enable),
        .port_address     (port_address),
        .port_wdata       (port_wdata),
        .port_resp        (port_resp),
        .port_rdata       (port_rdata),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_resp         (mem_resp),
        .mem_rdata        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        port_read        = '0;
        port_write       = '0;
        port_byte_enable = '0;
        port_address     = '0;
        port_wdata       = '0;
    endtask

    task automatic set_ch(input int ch, input logic rd, input logic wr, input logic [MW-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
        port_read[ch]               = rd;
        port_write[ch]              = wr;
        port_byte_enable[ch*MW +: MW] = be;
        port_address[ch*AW +: AW]   = addr;
        port_wdata[ch*DW +: DW]     = data;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        mem_resp = 1'b0;
        mem_rdata = '0;
        clear_all();
        cyc();
        reset = 1'b0;
    endtask

    // Pulse mem_resp for one cycle, expect the given pulse, then expect a quiet IDLE cycle.
    task automatic finish_resp(input string tag, input logic [DW-1:0] data,
                               input logic [NP-1:0] exp_resp);
        mem_resp  = 1'b1;
        mem_rdata = data;
        #1;
        chk({tag, ".resp"}, 48'(port_resp), 48'(exp_resp));
        chk({tag, ".rdata"}, 48'(port_rdata), 48'(data));
        cyc();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        chk({tag, ".resp_off"}, 48'(port_resp), 48'd0);
        chk({tag, ".strobes_off"}, 48'({mem_read, mem_write}), 48'd0);
    endtask

    // Reference round-robin: first pending channel after last, modulo NP.
    function automatic int model_pick(input bit [NP-1:0] pend, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (pend[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    bit [NP-1:0]    pend;
    int             op    [NP];
    logic [AW-1:0]  raddr [NP];
    logic [DW-1:0]  rdat  [NP];
    logic [MW-1:0]  rbe   [NP];

    task automatic drive_pending();
        clear_all();
        for (int c = 0; c < NP; c++) begin
            if (pend[c]) begin
                set_ch(c, op[c] != 1, op[c] != 0, rbe[c], raddr[c], rdat[c]);
            end
        end
    endtask

    initial begin
        int last;
        int g;
        int lat;

        reset     = 1'b1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        clear_all();
        cyc();
        #1;
        chk("reset.strobes", 48'({mem_read, mem_write}), 48'd0);
        chk("reset.be", 48'(mem_byte_enable), 48'd0);
        chk("reset.addr", 48'(mem_address), 48'd0);
        chk("reset.wdata", 48'(mem_wdata), 48'd0);
        chk("reset.resp", 48'(port_resp), 48'd0);
        cyc();
        reset = 1'b0;

        // Single read, memory answers in the third BUSY cycle.
        set_ch(0, 1'b1, 1'b0, 2'b11, 16'h1234, 16'h0000);
        #1;
        chk("rd.pre_grant_read", 48'(mem_read), 48'd0);
        cyc();
        #1;
        chk("rd.mem_read", 48'(mem_read), 48'd1);
        chk("rd.mem_write", 48'(mem_write), 48'd0);
        chk("rd.addr", 48'(mem_address), 48'h1234);
        cyc();
        cyc();
        clear_all();
        finish_resp("rd", 16'hBEEF, 3'b001);

        // Contention from reset: ch0 read then ch1 write.
        do_reset();
        set_ch(0, 1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000);
        set_ch(1, 1'b0, 1'b1, 2'b11, 16'h0020, 16'hA5A5);
        cyc();
        #1;
        chk("cont.first_addr", 48'(mem_address), 48'h0010);
        chk("cont.first_read", 48'(mem_read), 48'd1);
        set_ch(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        cyc();
        finish_resp("cont.a", 16'h0101, 3'b001);
        cyc();
        #1;
        chk("cont.second_write", 48'(mem_write), 48'd1);
        chk("cont.second_read", 48'(mem_read), 48'd0);
        chk("cont.second_addr", 48'(mem_address), 48'h0020);
        chk("cont.second_wdata", 48'(mem_wdata), 48'hA5A5);
        chk("cont.second_be", 48'(mem_byte_enable), 48'd3);
        clear_all();
        finish_resp("cont.b", 16'h0202, 3'b010);

        // Fairness: all three channels hold requests.
        do_reset();
        for (int c = 0; c < NP; c++) set_ch(c, 1'b1, 1'b0, 2'b11, 16'(16'h0100 + c), 16'h0);
        for (int t = 0; t < 6; t++) begin
            cyc();
            #1;
            chk($sformatf("fair.addr%0d", t), 48'(mem_address), 48'(16'h0100 + (t % NP)));
            finish_resp($sformatf("fair%0d", t), 16'(t), 3'(1 << (t % NP)));
        end
        clear_all();

        // Stability: ch1 inputs change while BUSY.
        do_reset();
        set_ch(1, 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000);
        cyc();
        #1;
        chk("stab.addr0", 48'(mem_address), 48'h0040);
        set_ch(1, 1'b0, 1'b0, 2'b11, 16'h0042, 16'h0000);
        for (int t = 0; t < 2; t++) begin
            cyc();
            #1;
            chk($sformatf("stab.addr%0d", t + 1), 48'(mem_address), 48'h0040);
            chk($sformatf("stab.read%0d", t + 1), 48'(mem_read), 48'd1);
        end
        finish_resp("stab", 16'h4242, 3'b010);

        // Read and write together: write wins.
        do_reset();
        set_ch(0, 1'b1, 1'b1, 2'b01, 16'h0055, 16'h1111);
        cyc();
        #1;
        chk("rw.write", 48'(mem_write), 48'd1);
        chk("rw.read", 48'(mem_read), 48'd0);
        chk("rw.be", 48'(mem_byte_enable), 48'd1);
        clear_all();
        finish_resp("rw", 16'h0, 3'b001);

        // Reset in BUSY, then a stray mem_resp.
        do_reset();
        set_ch(1, 1'b1, 1'b0, 2'b11, 16'h0077, 16'h0000);
        cyc();
        #1;
        chk("rst.busy_read", 48'(mem_read), 48'd1);
        clear_all();
        reset = 1'b1;
        #1;
        chk("rst.read_now", 48'(mem_read), 48'd0);
        chk("rst.addr_now", 48'(mem_address), 48'd0);
        cyc();
        reset    = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("rst.stray_resp", 48'(port_resp), 48'd0);
        cyc();
        mem_resp = 1'b0;
        set_ch(0, 1'b1, 1'b0, 2'b11, 16'h0088, 16'h0000);
        set_ch(1, 1'b1, 1'b0, 2'b11, 16'h0099, 16'h0000);
        cyc();
        #1;
        chk("rst.next_addr", 48'(mem_address), 48'h0088);
        clear_all();
        finish_resp("rst", 16'h0, 3'b001);

        // Randomized traffic against the round-robin model.
        do_reset();
        pend = '0;
        last = NP - 1;
        for (int n = 0; n < 80; n++) begin
            for (int c = 0; c < NP; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    pend[c]  = 1'b1;
                    op[c]    = int'($urandom_range(0, 2));
                    raddr[c] = 16'($urandom);
                    rdat[c]  = 16'($urandom);
                    rbe[c]   = 2'($urandom_range(0, 3));
                end
            end
            if (pend == '0) begin
                g        = int'($urandom_range(0, NP - 1));
                pend[g]  = 1'b1;
                op[g]    = 0;
                raddr[g] = 16'($urandom);
                rdat[g]  = 16'($urandom);
                rbe[g]   = 2'b11;
            end
            drive_pending();
            g = model_pick(pend, last);
            cyc();
            #1;
            chk($sformatf("rnd%0d.addr", n), 48'(mem_address), 48'(raddr[g]));
            chk($sformatf("rnd%0d.wdata", n), 48'(mem_wdata), 48'(rdat[g]));
            chk($sformatf("rnd%0d.be", n), 48'(mem_byte_enable), 48'(rbe[g]));
            chk($sformatf("rnd%0d.rw", n), 48'({mem_read, mem_write}),
                48'({op[g] == 0, op[g] != 0}));
            lat = int'($urandom_range(0, 3));
            for (int w = 0; w < lat; w++) begin
                set_ch(g, 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
                cyc();
                #1;
                chk($sformatf("rnd%0d.hold", n), 48'(mem_address), 48'(raddr[g]));
                chk($sformatf("rnd%0d.quiet", n), 48'(port_resp), 48'd0);
            end
            pend[g] = 1'b0;
            drive_pending();
            finish_resp($sformatf("rnd%0d", n), 16'($urandom), 3'(1 << g));
            last = g;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that shares one LC-3b-style memory port (read/write/byte-enable/address/wdata in; resp/rdata out) among several requesters.
- Typical use: split instruction-fetch and data-access paths of the CPU onto a single physical memory; scales to extra masters (e.g. DMA) through NUM_PORTS.
- Round-robin fair, one transaction in flight, command latched at grant so the downstream port sees stable registered signals.

Parameters:
- NUM_PORTS, 2, number of requesting channels (>=2).
- ADDR_WIDTH, 16, address width in bits.
- DATA_WIDTH, 16, data width in bits (multiple of 8).
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- port_read  in  NUM_PORTS  per-channel read request, bit i = channel i.
- port_write  in  NUM_PORTS  per-channel write request.
- port_byte_enable  in  NUM_PORTS*MASK_WIDTH  byte enables, channel i in slice [i*MASK_WIDTH +: MASK_WIDTH].
- port_address  in  NUM_PORTS*ADDR_WIDTH  addresses, packed the same way.
- port_wdata  in  NUM_PORTS*DATA_WIDTH  write data, packed the same way.
- port_resp  out  NUM_PORTS  one-cycle completion pulse to the granted channel.
- port_rdata  out  DATA_WIDTH  read data broadcast to all channels; valid only with port_resp.
- mem_read  out  1  downstream read strobe (registered).
- mem_write  out  1  downstream write strobe (registered).
- mem_byte_enable  out  MASK_WIDTH  downstream byte enables (registered).
- mem_address  out  ADDR_WIDTH  downstream address (registered).
- mem_wdata  out  DATA_WIDTH  downstream write data (registered).
- mem_resp  in  1  downstream completion.
- mem_rdata  in  DATA_WIDTH  downstream read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values:
  - FSM = IDLE.
  - mem_read = mem_write = 0; mem_byte_enable, mem_address, mem_wdata = 0.
  - port_resp = 0.
  - last_grant = NUM_PORTS-1, so channel 0 has first priority.
- Channel i requests when port_read[i] | port_write[i].
- FSM IDLE:
  - If any request is present, select the first requesting channel scanning last_grant+1, last_grant+2, ... (mod NUM_PORTS).
  - Latch the selected channel into grant and its address, wdata and byte_enable into the mem_* registers.
  - Set mem_write = port_write[g] and mem_read = port_read[g] & ~port_write[g]. Write wins if both are asserted.
  - Go to BUSY. Downstream strobes are visible the cycle after the request is sampled (1-cycle arbitration latency).
  - mem_resp while in IDLE is ignored.
- FSM BUSY:
  - Hold all mem_* outputs stable.
  - Changes or drops on any port input are ignored; latched values stand.
  - On mem_resp: port_resp[grant] = 1 combinationally in the same cycle; port_rdata = mem_rdata (continuous pass-through).
  - Same edge: last_grant <= grant, mem_read/mem_write <= 0, go to IDLE.
- Back-to-back: after a resp cycle there is one IDLE cycle, then the next grant. Minimum transaction = 2 cycles + memory latency.
- Fairness: a channel that keeps requesting cannot be granted twice in a row while another channel is requesting.
- port_resp is never asserted to a non-granted channel, and never for more than one cycle per transaction.
- Reset mid-BUSY: the transaction is abandoned, outputs take reset values immediately, and a later mem_resp is ignored in IDLE.
- NUM_PORTS need not be a power of two; the grant index wrap uses an explicit compare, not bit truncation.

Decomposition:
- lc3b_types additions:
  - lc3b_mem_wmask is reused for the MASK_WIDTH=2 case.
  - Add enum arb_state_t {ARB_IDLE, ARB_BUSY}.
- Sub-module rr_picker: combinational round-robin selector.
  - Inputs: request vector, last_grant.
  - Outputs: grant index, any_req.
  - Parametrised on NUM_PORTS; reused later by the cache write-back arbiter.

Test Plan:
- Single read: ch0 read addr 0x1234, mem_resp after 3 cycles with rdata 0xBEEF -> mem_read rises 1 cycle after request with mem_address=0x1234; port_resp=01 in the mem_resp cycle with port_rdata=0xBEEF.
- Contention, NUM_PORTS=2: ch0 read 0x0010 and ch1 write 0x0020/0xA5A5 mask 11 asserted together from reset -> ch0 served first, then ch1 (mem_write=1, mem_wdata=0xA5A5); port_resp pulses 01 then 10.
- Fairness, NUM_PORTS=3: all three channels hold requests for 6 transactions -> grant order 0,1,2,0,1,2, and no port_resp pulse is wider than 1 cycle.
- Stability: ch1 changes address 0x0040->0x0042 and drops read while BUSY -> mem_address stays 0x0040 and mem_read stays 1 until mem_resp.
- Read+write conflict: ch0 read=write=1, mask 01 -> mem_write=1, mem_read=0, mem_byte_enable=01.
- Reset mid-op: reset asserted in BUSY, then mem_resp pulsed -> mem_read=0 immediately, port_resp stays 0, next request is granted to ch0.
